key_expansion_seq: RTL and testbench

KEY_EXPANSION_SEQ -- requirements
Module: key_expansion_seq

---
 rtl/key_expansion_seq_pkg.sv | 73 +++++++
 rtl/key_expansion_seq_subtable.sv | 24 ++
 rtl/key_expansion_seq.sv | 144 ++++++++++++++
 tb/tb_key_expansion_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_expansion_seq_pkg.sv
// Shared types and lookups for the AES key-schedule generator.
package key_expansion_seq_pkg;

    typedef enum logic [1:0] {
        KS_128  = 2'b00,
        KS_192  = 2'b01,
        KS_256  = 2'b10,
        KS_RSVD = 2'b11
    } key_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXPAND = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    localparam int MAX_WORDS = 60;

    function automatic logic [3:0] nk_of(input key_size_e ks);
        case (ks)
            KS_192:  return 4'd6;
            KS_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_size_e ks);
        case (ks)
            KS_192:  return 4'd12;
            KS_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    // Words in the full schedule: 4*(Nr+1).
    function automatic logic [5:0] total_words_of(input key_size_e ks);
        case (ks)
            KS_192:  return 6'd52;
            KS_256:  return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

    // Index 0 holds Rcon[1]; Rcon[n+1] = xtime(Rcon[n]).
    function automatic logic [7:0] rcon_of(input logic [3:0] n);
        case (n)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/key_expansion_seq_subtable.sv
// SubTable: AES S-box for one byte, built as GF(2^8) inverse followed by the affine map.
module key_expansion_seq_subtable
    import key_expansion_seq_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box requires.
    always_comb begin
        sq  = in_i;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/key_expansion_seq.sv
// Sequential AES key expansion: one schedule word per cycle into a 60-word register file,
// with random-access read of any round key.
module key_expansion_seq
    import key_expansion_seq_pkg::*;
#(
    parameter bit ROUND_KEY_REG = 1'b0,
    parameter int MAX_KEY_BITS  = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   keySize,
    input  logic [255:0] keyIn,
    input  logic [3:0]   roundKeyIdx,
    output logic [127:0] roundKeyOut,
    output logic         busy,
    output logic         done,
    output logic         err,
    output state_e       dbg_state_o
);

    state_e    state_q, state_d;
    logic [5:0] i_q, i_d;
    logic [3:0] j_q, j_d;
    logic [3:0] rci_q, rci_d;
    key_size_e ks_q, ks_d;
    logic      err_q, err_d;
    logic [31:0] w_q [MAX_WORDS];

    key_size_e ks_in;
    logic      legal;
    logic      accept;
    logic      write_en;
    logic [3:0] nk;
    logic [31:0] prev_w, back_w, sub_in, sub_out, temp, new_w;
    logic [5:0]  base;
    logic [127:0] rk_comb;

    assign ks_in = key_size_e'(keySize);
    assign legal = (ks_in != KS_RSVD) && (32 * int'(nk_of(ks_in)) <= MAX_KEY_BITS);
    assign nk    = nk_of(ks_q);

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        rci_d    = rci_q;
        ks_d     = ks_q;
        err_d    = 1'b0;
        accept   = 1'b0;
        write_en = 1'b0;
        case (state_q)
            ST_EXPAND: begin
                write_en = 1'b1;
                i_d      = i_q + 6'd1;
                j_d      = (j_q == nk - 4'd1) ? 4'd0 : j_q + 4'd1;
                if (j_q == 4'd0) rci_d = rci_q + 4'd1;
                if (i_q == total_words_of(ks_q) - 6'd1) state_d = ST_DONE;
            end
            default: begin
                if (start) begin
                    if (legal) begin
                        accept  = 1'b1;
                        ks_d    = ks_in;
                        i_d     = {2'b00, nk_of(ks_in)};
                        j_d     = 4'd0;
                        rci_d   = 4'd0;
                        state_d = ST_EXPAND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // j_q tracks i mod Nk so no divider is needed.
    assign prev_w = w_q[i_q - 6'd1];
    assign back_w = w_q[i_q - {2'b00, nk}];
    assign sub_in = (j_q == 4'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        key_expansion_seq_subtable u_subtable (
            .in_i  (sub_in[8*b +: 8]),
            .out_o (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev_w;
        if (j_q == 4'd0) begin
            temp = sub_out ^ {rcon_of(rci_q), 24'h000000};
        end else if (nk == 4'd8 && j_q == 4'd4) begin
            temp = sub_out;
        end
        new_w = back_w ^ temp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            i_q     <= 6'd0;
            j_q     <= 4'd0;
            rci_q   <= 4'd0;
            ks_q    <= KS_128;
            err_q   <= 1'b0;
            for (int k = 0; k < MAX_WORDS; k++) w_q[k] <= 32'h0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rci_q   <= rci_d;
            ks_q    <= ks_d;
            err_q   <= err_d;
            if (accept) begin
                for (int k = 0; k < 8; k++) begin
                    if (k < int'(nk_of(ks_in))) w_q[k] <= keyIn[255 - 32*k -: 32];
                end
            end
            if (write_en) w_q[i_q] <= new_w;
        end
    end

    assign base    = {roundKeyIdx, 2'b00};
    assign rk_comb = (roundKeyIdx > nr_of(ks_q)) ? 128'h0 :
                     {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};

    if (ROUND_KEY_REG) begin : g_rk_reg
        logic [127:0] rko_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) rko_q <= 128'h0;
            else       rko_q <= rk_comb;
        end
        assign roundKeyOut = rko_q;
    end else begin : g_rk_comb
        assign roundKeyOut = rk_comb;
    end

    assign busy        = (state_q == ST_EXPAND);
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: FIPS-197 vectors plus a table-driven key-schedule model.
module tb_key_expansion_seq;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdef_fedcba9876543210};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hdeadbeef_cafef00d};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam int M_IDLE = 0;
    localparam int M_EXP  = 1;
    localparam int M_DONE = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   keySize = 2'b00;
    logic [255:0] keyIn = '0;
    logic [3:0]   roundKeyIdx = 4'd0;
    logic [127:0] roundKeyOut;
    logic         busy, done, err;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    key_expansion_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .keySize     (keySize),
        .keyIn       (keyIn),
        .roundKeyIdx (roundKeyIdx),
        .roundKeyOut (roundKeyOut),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    logic [7:0] rcon_l [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Model state
    logic [31:0] m_w [60];
    int   m_state = M_IDLE;
    int   m_left  = 0;
    int   m_nr    = 10;
    logic m_err   = 1'b0;
    logic m_clean = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [127:0] row;
        row = sbox_rows[b[7:4]];
        return row[127 - 8*b[3:0] -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    task automatic build(input logic [255:0] key, input int nk);
        logic [31:0] t;
        for (int i = 0; i < nk; i++) m_w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = m_w[i-1];
            if (i % nk == 0)
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon_l[i/nk - 1], 24'h0};
            else if (nk == 8 && i % 8 == 4)
                t = sub_word(t);
            m_w[i] = m_w[i-nk] ^ t;
        end
        m_nr = nk + 6;
    endtask

    function automatic logic [127:0] exp_rk(input logic [3:0] idx);
        int r;
        r = int'(idx);
        if (r > m_nr) return 128'h0;
        return {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
    endfunction

    initial for (int i = 0; i < 60; i++) m_w[i] = 32'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = M_IDLE;
            m_left  = 0;
            m_err   = 1'b0;
            m_clean = 1'b1;
        end else begin
            m_err = 1'b0;
            if (m_state == M_EXP) begin
                m_left--;
                if (m_left == 0) m_state = M_DONE;
            end else if (start) begin
                if (keySize == 2'b11) begin
                    m_err = 1'b1;
                end else begin
                    build(keyIn, 4 + 2*int'(keySize));
                    m_left  = 4*(m_nr+1) - (4 + 2*int'(keySize));
                    m_state = M_EXP;
                    m_clean = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_state == M_EXP);
        chk("done", done, m_state == M_DONE);
        chk("err", err, m_err);
        if (m_state == M_DONE)
            chk("round_key", roundKeyOut, exp_rk(roundKeyIdx));
        else if (m_clean)
            chk("round_key_clean", roundKeyOut, 128'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [3:0] idx, input logic [127:0] want);
        roundKeyIdx = idx;
        #1;
        chk(name, roundKeyOut, want);
    endtask

    task automatic run_key(input logic [1:0] ks, input logic [255:0] key, input int lat, input int inject_at);
        int c;
        exp_q.push_back(lat);
        start   = 1'b1;
        keySize = ks;
        keyIn   = key;
        tick();
        start = 1'b0;
        keyIn = '0;
        c = 0;
        while (!done && c < 200) begin
            if (c == inject_at) begin
                start   = 1'b1;
                keySize = 2'b10;
                keyIn   = K256;
            end else begin
                start = 1'b0;
            end
            tick();
            c++;
        end
        start = 1'b0;
        chk("done_latency", c, exp_q.pop_front());
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rko", roundKeyOut, 128'h0);
        reset = 1'b0;
        tick();

        run_key(2'b00, K128, 40, -1);
        rd("aes128_idx0", 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd("aes128_idx1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd("aes128_idx10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd("aes128_idx11", 4'd11, 128'h0);

        start = 1'b1;
        keySize = 2'b11;
        tick();
        start = 1'b0;
        chk("rsvd_err", err, 1'b1);
        chk("rsvd_done", done, 1'b1);
        chk("rsvd_busy", busy, 1'b0);
        tick();
        chk("rsvd_err_clear", err, 1'b0);
        chk("rsvd_done_hold", done, 1'b1);

        run_key(2'b01, K192, 46, -1);
        rd("aes192_idx12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);
        rd("aes192_idx13", 4'd13, 128'h0);

        run_key(2'b10, K256, 52, -1);
        rd("aes256_idx14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        rd("aes256_idx0", 4'd0, 128'h603deb1015ca71be2b73aef0857d7781);

        run_key(2'b00, K128, 40, 5);
        rd("busy_start_idx1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd("busy_start_idx10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        start = 1'b1;
        keySize = 2'b10;
        keyIn = K256;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("mid_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        rd("mid_rst_rko", 4'd1, 128'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        chk("post_rst_idle_busy", busy, 1'b0);
        chk("post_rst_idle_done", done, 1'b0);

        run_key(2'b00, K128, 40, -1);
        rd("rerun_idx1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd("rerun_idx10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd("rerun_idx11", 4'd11, 128'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
